decoder_ambig_ctrl: RTL and testbench
=====================================

DECODER_AMBIG_CTRL -- requirements
Module: decoder_ambig_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 16, giving the width of dwell_len and of the internal window counter.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rs_n, input, 1, the reset, asynchronous and active-low.
REQ-004 The block SHALL have port symb_clk_en, input, 1, the one-clk symbol strobe.
REQ-005 The block SHALL have port sync_hit, input, 1, the frame-sync correlator hit, valid only when symb_clk_en=1.
REQ-006 The block SHALL have port enable, input, 1; 1 runs the search and 0 forces IDLE.
REQ-007 The block SHALL have port dwell_len, input, DWELL_W, the window length in symbols.
REQ-008 The block SHALL have port lock_thresh, input, 4, the number of consecutive windowed hits needed to declare lock.
REQ-009 The block SHALL have port miss_thresh, input, 4, the number of consecutive missed windows in LOCK that drops lock.
REQ-010 The block SHALL have port swap, output, 1, the I/Q swap control to the decoder.
REQ-011 The block SHALL have port data_inv, output, 1, the data-inversion control to the decoder.
REQ-012 The block SHALL have port locked, output, 1, high while in LOCK.
REQ-013 The block SHALL have port state, output, 2: IDLE=0, SEARCH=1, VERIFY=2, LOCK=3.
REQ-014 The block SHALL have port hyp_chg, output, 1, a one-clk pulse whenever {swap,data_inv} changes, used to flush downstream.

Function
REQ-015 The block SHALL hold a 2-bit hypothesis hyp; {swap,data_inv} = {hyp[1],hyp[0]}, registered, and updated on the clk following the deciding edge.
REQ-016 The window counter SHALL increment only on symb_clk_en, and the window SHALL expire on the symb_clk_en at which count == eff_dwell-1; eff_dwell = max(dwell_len,1).
REQ-017 A qualified hit (sync_hit & symb_clk_en) SHALL zero the window counter; on the same strobe, a hit SHALL take precedence over expiry.
REQ-018 The block SHALL treat sync_hit with symb_clk_en=0 as ignored.
REQ-019 In IDLE with enable=1, the block SHALL go to SEARCH with the window counter at 0 and hyp unchanged.
REQ-020 In SEARCH, a qualified hit SHALL set hit_cnt=1 and go to VERIFY; if eff_lock_thresh=1, the hit SHALL go directly to LOCK. eff_lock_thresh = max(lock_thresh,1).
REQ-021 In SEARCH, window expiry without a hit SHALL advance hyp (3 wraps to 0), pulse hyp_chg, and remain in SEARCH.
REQ-022 In VERIFY, each hit SHALL increment hit_cnt; when hit_cnt reaches eff_lock_thresh, the block SHALL enter LOCK.
REQ-023 In VERIFY, expiry without a hit SHALL advance hyp, pulse hyp_chg, clear hit_cnt, and return to SEARCH.
REQ-024 In LOCK, a hit SHALL clear miss_cnt; expiry without a hit SHALL increment miss_cnt.
REQ-025 In LOCK, when miss_cnt reaches eff_miss (max(miss_thresh,1)), the block SHALL advance hyp, pulse hyp_chg, clear the counters, and go to SEARCH.
REQ-026 hit_cnt and miss_cnt SHALL saturate at 15.
REQ-027 enable=0 in any state SHALL force IDLE on the next clk, clear all counters, and retain hyp; locked SHALL fall on that same clk.
REQ-028 Changes to dwell_len or either threshold mid-window SHALL take effect at the next comparison, with no restart.

Reset
REQ-029 While rs_n=0, the block SHALL hold state=IDLE, hyp=0, swap=0, data_inv=0, locked=0, hyp_chg=0, and all counters at 0.
REQ-030 On rs_n rising, the block SHALL resume from IDLE on the first clk.
REQ-031 Reset asserted mid-operation SHALL abort the search immediately and asynchronously.

Configuration
REQ-032 The macro DECODER_AMBIG_INV_SEARCH_EN SHALL control the search set.
REQ-033 With DECODER_AMBIG_INV_SEARCH_EN defined, the block SHALL search four hypotheses in the order 0,1,2,3.
REQ-034 Without DECODER_AMBIG_INV_SEARCH_EN, hyp[0] SHALL be tied to 0, data_inv SHALL be constant 0, and hyp SHALL step 0,2,0,2, i.e. swap only.

Verification
REQ-035 Config dwell_len=8, lock_thresh=3, no hits -> hyp advances every 8 symbols with hyp_chg pulses, sequence 1,2,3,0 (macro on) or 2,0 (macro off).
REQ-036 Config dwell_len=8, lock_thresh=3, hits every 8 symbols starting in hyp=2 -> VERIFY after the 1st hit, LOCK after the 3rd, swap=1, data_inv=0, locked=1.
REQ-037 Config dwell_len=8, miss_thresh=2, in LOCK with hits stopped -> two expiries then SEARCH, hyp+1, locked=0; a single miss followed by a hit stays in LOCK.
REQ-038 Hit and expiry on the same symb_clk_en -> treated as a hit; no hyp change.
REQ-039 Config dwell_len=0, lock_thresh=0 -> window is 1 symbol and the first hit locks directly from SEARCH.
REQ-040 Deassert rs_n or enable during VERIFY -> IDLE next edge; on reset, hyp=0; on enable=0, hyp is held.

Source files
------------

// File: rtl/decoder_ambig_ctrl.sv
// Phase-ambiguity resolver for a frame-synced decoder: steps the {swap,data_inv}
// hypothesis until sync hits lock. Define DECODER_AMBIG_INV_SEARCH_EN to search inversion too.
module decoder_ambig_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rs_n,
  input  logic               symb_clk_en,
  input  logic               sync_hit,
  input  logic               enable,
  input  logic [DWELL_W-1:0] dwell_len,
  input  logic [3:0]         lock_thresh,
  input  logic [3:0]         miss_thresh,
  output logic               swap,
  output logic               data_inv,
  output logic               locked,
  output logic [1:0]         state,
  output logic               hyp_chg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2,
    LOCK   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         hyp_q, hyp_d;
  logic [DWELL_W-1:0] win_q, win_d;
  logic [3:0]         hit_q, hit_d;
  logic [3:0]         miss_q, miss_d;
  logic               chg_q, chg_d;

  logic               qual_hit;
  logic               expire;
  logic [DWELL_W-1:0] last_idx;
  logic [3:0]         eff_lock;
  logic [3:0]         eff_miss;
  logic [3:0]         hit_inc;
  logic [3:0]         miss_inc;

  function automatic logic [1:0] next_hyp(input logic [1:0] h);
`ifdef DECODER_AMBIG_INV_SEARCH_EN
    return h + 2'd1;
`else
    return {~h[1], 1'b0};
`endif
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  assign qual_hit = sync_hit & symb_clk_en;
  assign last_idx = (dwell_len == '0) ? '0 : dwell_len - DWELL_W'(1);
  // >= rather than == so a dwell_len shrunk below the running count still expires next strobe.
  assign expire   = symb_clk_en & (win_q >= last_idx);
  assign eff_lock = (lock_thresh == 4'd0) ? 4'd1 : lock_thresh;
  assign eff_miss = (miss_thresh == 4'd0) ? 4'd1 : miss_thresh;
  assign hit_inc  = sat_inc(hit_q);
  assign miss_inc = sat_inc(miss_q);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latches).
    state_d = state_q;
    hyp_d   = hyp_q;
    win_d   = win_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    chg_d   = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      win_d   = '0;
      hit_d   = 4'd0;
      miss_d  = 4'd0;
    end else if (state_q == IDLE) begin
      state_d = SEARCH;
      win_d   = '0;
    end else if (symb_clk_en) begin
      win_d = (qual_hit || expire) ? '0 : win_q + DWELL_W'(1);
      case (state_q)
        SEARCH: begin
          if (qual_hit) begin
            hit_d   = 4'd1;
            state_d = (eff_lock == 4'd1) ? LOCK : VERIFY;
          end else if (expire) begin
            hyp_d = next_hyp(hyp_q);
            chg_d = 1'b1;
          end
        end
        VERIFY: begin
          if (qual_hit) begin
            hit_d = hit_inc;
            if (hit_inc >= eff_lock) state_d = LOCK;
          end else if (expire) begin
            hyp_d   = next_hyp(hyp_q);
            chg_d   = 1'b1;
            hit_d   = 4'd0;
            state_d = SEARCH;
          end
        end
        LOCK: begin
          if (qual_hit) begin
            miss_d = 4'd0;
          end else if (expire) begin
            if (miss_inc >= eff_miss) begin
              hyp_d   = next_hyp(hyp_q);
              chg_d   = 1'b1;
              hit_d   = 4'd0;
              miss_d  = 4'd0;
              state_d = SEARCH;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: ;
      endcase
    end

`ifndef DECODER_AMBIG_INV_SEARCH_EN
    hyp_d[0] = 1'b0;
`endif
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      state_q <= IDLE;
      hyp_q   <= 2'd0;
      win_q   <= '0;
      hit_q   <= 4'd0;
      miss_q  <= 4'd0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hyp_q   <= hyp_d;
      win_q   <= win_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      chg_q   <= chg_d;
    end
  end

  assign swap     = hyp_q[1];
  assign data_inv = hyp_q[0];
  assign locked   = (state_q == LOCK);
  assign state    = state_q;
  assign hyp_chg  = chg_q;

endmodule

// File: tb/tb_decoder_ambig_ctrl.sv
// Self-checking bench for decoder_ambig_ctrl: directed scenarios plus randomized
// traffic, every cycle compared against a symbol-level behavioural model.
module tb_decoder_ambig_ctrl;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rs_n;
  logic          symb_clk_en;
  logic          sync_hit;
  logic          enable;
  logic [DW-1:0] dwell_len;
  logic [3:0]    lock_thresh;
  logic [3:0]    miss_thresh;
  logic          swap;
  logic          data_inv;
  logic          locked;
  logic [1:0]    state;
  logic          hyp_chg;

  decoder_ambig_ctrl #(.DWELL_W(DW)) dut (
    .clk         (clk),
    .rs_n        (rs_n),
    .symb_clk_en (symb_clk_en),
    .sync_hit    (sync_hit),
    .enable      (enable),
    .dwell_len   (dwell_len),
    .lock_thresh (lock_thresh),
    .miss_thresh (miss_thresh),
    .swap        (swap),
    .data_inv    (data_inv),
    .locked      (locked),
    .state       (state),
    .hyp_chg     (hyp_chg)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int chg_seen  = 0;

  // Model: 0=IDLE 1=SEARCH 2=VERIFY 3=LOCK; hyp as an integer 0..3.
  int m_state, m_hyp, m_win, m_hit, m_miss;
  bit m_chg;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int advance(input int h);
`ifdef DECODER_AMBIG_INV_SEARCH_EN
    return (h + 1) % 4;
`else
    return (h + 2) % 4;
`endif
  endfunction

  function automatic int min15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_hyp = 0; m_win = 0; m_hit = 0; m_miss = 0; m_chg = 0;
  endtask

  // One clk of behaviour, evaluated from the inputs present at the edge.
  task automatic model_clk();
    int eff_d, eff_l, eff_m;
    bit h, ex;
    m_chg = 0;
    if (!enable) begin
      m_state = 0; m_win = 0; m_hit = 0; m_miss = 0;
      return;
    end
    if (m_state == 0) begin
      m_state = 1; m_win = 0;
      return;
    end
    if (!symb_clk_en) return;
    eff_d = (dwell_len == 0) ? 1 : int'(dwell_len);
    eff_l = (lock_thresh == 0) ? 1 : int'(lock_thresh);
    eff_m = (miss_thresh == 0) ? 1 : int'(miss_thresh);
    h  = sync_hit;
    ex = (m_win >= eff_d - 1);
    m_win = (h || ex) ? 0 : m_win + 1;
    if (m_state == 1) begin
      if (h) begin
        m_hit = 1;
        m_state = (eff_l == 1) ? 3 : 2;
      end else if (ex) begin
        m_hyp = advance(m_hyp); m_chg = 1;
      end
    end else if (m_state == 2) begin
      if (h) begin
        m_hit = min15(m_hit + 1);
        if (m_hit >= eff_l) m_state = 3;
      end else if (ex) begin
        m_hyp = advance(m_hyp); m_chg = 1; m_hit = 0; m_state = 1;
      end
    end else begin
      if (h) m_miss = 0;
      else if (ex) begin
        m_miss = min15(m_miss + 1);
        if (m_miss >= eff_m) begin
          m_hyp = advance(m_hyp); m_chg = 1; m_hit = 0; m_miss = 0; m_state = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("state",    state,    m_state);
    check("swap",     swap,     m_hyp / 2);
    check("data_inv", data_inv, m_hyp % 2);
    check("locked",   locked,   (m_state == 3) ? 1 : 0);
    check("hyp_chg",  hyp_chg,  m_chg);
  endtask

  task automatic step();
    @(posedge clk);
    model_clk();
    @(negedge clk);
    compare_all();
    if (hyp_chg === 1'b1) chg_seen++;
  endtask

  // One symbol: a strobe clk, then a gap clk carrying a stray unqualified hit.
  task automatic sym(input bit h);
    symb_clk_en = 1'b1; sync_hit = h;
    step();
    symb_clk_en = 1'b0; sync_hit = 1'b1;
    step();
    sync_hit = 1'b0;
  endtask

  task automatic syms(input int n);
    for (int i = 0; i < n; i++) sym(1'b0);
  endtask

  task automatic async_reset();
    #2 rs_n = 1'b0;
    #1;
    check("rst_state",   state,    0);
    check("rst_swap",    swap,     0);
    check("rst_inv",     data_inv, 0);
    check("rst_locked",  locked,   0);
    check("rst_hyp_chg", hyp_chg,  0);
    model_reset();
    @(negedge clk);
    rs_n = 1'b1;
  endtask

  int hyp_before;

  initial begin
    rs_n = 1'b0; enable = 1'b0; symb_clk_en = 1'b0; sync_hit = 1'b0;
    dwell_len = 16'd8; lock_thresh = 4'd3; miss_thresh = 4'd2;
    model_reset();
    @(negedge clk);
    compare_all();
    rs_n = 1'b1;
    repeat (3) step();

    // No hits: hypothesis steps every 8 symbols.
    enable = 1'b1;
    step();
    check("search_entry", state, 1);
    chg_seen = 0;
    syms(32);
    check("nohit_chg_count", chg_seen, 4);
    check("nohit_hyp_wrap", {swap, data_inv}, 0);

    // Move to hyp=2, then three hits 8 symbols apart.
`ifdef DECODER_AMBIG_INV_SEARCH_EN
    syms(16);
`else
    syms(8);
`endif
    check("hyp_at_2", {swap, data_inv}, 2);
    sym(1'b1);
    check("verify_after_1st", state, 2);
    for (int i = 0; i < 2; i++) begin
      syms(7);
      sym(1'b1);
    end
    check("lock_after_3rd", state, 3);
    check("lock_locked", locked, 1);
    check("lock_swap", swap, 1);
    check("lock_inv", data_inv, 0);

    // One missed window then a hit stays locked; two misses drop lock.
    syms(8);
    sym(1'b1);
    check("one_miss_stays", state, 3);
    syms(16);
    check("two_miss_search", state, 1);
    check("two_miss_unlocked", locked, 0);
`ifdef DECODER_AMBIG_INV_SEARCH_EN
    check("two_miss_hyp", {swap, data_inv}, 3);
`else
    check("two_miss_hyp", {swap, data_inv}, 0);
`endif

    // Hit coincident with expiry counts as a hit.
    syms(7);
    hyp_before = {30'd0, swap, data_inv};
    chg_seen = 0;
    sym(1'b1);
    check("coincide_verify", state, 2);
    check("coincide_no_chg", chg_seen, 0);
    check("coincide_hyp", {swap, data_inv}, hyp_before);

    // enable low in VERIFY holds hyp; reset in VERIFY clears it.
    enable = 1'b0;
    step();
    check("disable_idle", state, 0);
    check("disable_hyp_held", {swap, data_inv}, hyp_before);
    enable = 1'b1;
    step();
    sym(1'b1);
    check("reverify", state, 2);
    async_reset();
    step();
    check("resume_search", state, 1);

    // Zero dwell and zero lock threshold: 1-symbol window, direct lock.
    dwell_len = 16'd0; lock_thresh = 4'd0;
    chg_seen = 0;
    syms(3);
    check("dwell0_chg_count", chg_seen, 3);
    sym(1'b1);
    check("lock0_direct", state, 3);

    // Randomized traffic with mid-window configuration changes.
    for (int i = 0; i < 4000; i++) begin
      symb_clk_en = ($urandom % 2) == 0;
      sync_hit    = ($urandom % 4) == 0;
      enable      = ($urandom % 60) != 0;
      if (($urandom % 150) == 0) begin
        dwell_len   = DW'($urandom_range(0, 6));
        lock_thresh = 4'($urandom_range(0, 4));
        miss_thresh = 4'($urandom_range(0, 3));
      end
      step();
      if (($urandom % 500) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
